// File: rtl/cart_mapper.sv
// Atari 2600 cartridge bank-switching mapper: snoops the 6502 bus and drives ROM/Superchip addressing.
// Optional diagnostics port diag_o is enabled by defining MAPPER_DIAG_EN.
module cart_mapper #(
   parameter int unsigned ROM_ADDR_BITS = 15,
   parameter int unsigned SC_RAM_BITS   = 7,
   parameter int unsigned NUM_MODES     = 7
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic [2:0]               mode_i,
   input  logic                     sc_en_i,
   input  logic                     bus_stb_i,
   input  logic [12:0]              cpu_addr_i,
   input  logic                     cpu_rnw_i,
   input  logic [7:0]               cpu_data_i,
   output logic [ROM_ADDR_BITS-1:0] rom_addr_o,
   output logic [SC_RAM_BITS-1:0]   cart_ram_addr_o,
   output logic                     cart_ram_we_o,
   output logic                     cart_ram_rd_o,
`ifdef MAPPER_DIAG_EN
   output logic [15:0]              diag_o,
`endif
   output logic [2:0]               bank_o
);

   localparam logic [2:0]  MODE_NONE = 3'd0;
   localparam logic [2:0]  MODE_F8   = 3'd1;
   localparam logic [2:0]  MODE_F6   = 3'd2;
   localparam logic [2:0]  MODE_F4   = 3'd3;
   localparam logic [2:0]  MODE_FE   = 3'd4;
   localparam logic [2:0]  MODE_E0   = 3'd5;
   localparam logic [2:0]  MODE_3F   = 3'd6;
   localparam logic [12:0] FE_HOT    = 13'h01FE;

   typedef enum logic {
      FE_IDLE  = 1'b0,
      FE_ARMED = 1'b1
   } fe_state_e;

   logic [2:0] mode_q, mode_d;
   logic [2:0] bank_q, bank_d;
   logic [2:0] seg0_q, seg0_d;
   logic [2:0] seg1_q, seg1_d;
   logic [2:0] seg2_q, seg2_d;
   fe_state_e  fe_q, fe_d;

   logic [2:0]  mode_dec_c;
   logic        mode_chg_c;
   logic        sc_wr_port_c;
   logic        sc_rd_port_c;
   logic        strobe_c;
   logic [15:0] rom_addr_full_c;
   logic        unused_data_c;

   // Bank a mode starts in: the last bank, where the 6502 reset vector lives.
   function automatic logic [2:0] last_bank(input logic [2:0] mode);
      case (mode)
         MODE_F8: last_bank = 3'd1;
         MODE_F6: last_bank = 3'd3;
         MODE_F4: last_bank = 3'd7;
         default: last_bank = 3'd0;
      endcase
   endfunction

   assign mode_dec_c    = (32'(mode_q) < NUM_MODES) ? mode_q : MODE_NONE;
   assign mode_chg_c    = (mode_i != mode_q);
   assign sc_wr_port_c  = sc_en_i & cpu_addr_i[12] & (cpu_addr_i[11:7] == 5'b00000);
   assign sc_rd_port_c  = sc_en_i & cpu_addr_i[12] & (cpu_addr_i[11:7] == 5'b00001);
   // Superchip window accesses are never treated as hotspots.
   assign strobe_c      = bus_stb_i & ~(sc_wr_port_c | sc_rd_port_c);
   assign unused_data_c = ^{cpu_data_i[7:6], cpu_data_i[4:3]};

   // Next-state decode of hotspots and the FE/3F data snoops.
   always_comb begin
      mode_d = mode_q;
      bank_d = bank_q;
      seg0_d = seg0_q;
      seg1_d = seg1_q;
      seg2_d = seg2_q;
      fe_d   = fe_q;
      if (mode_chg_c) begin
         mode_d = mode_i;
         bank_d = last_bank(mode_i);
         seg0_d = 3'd0;
         seg1_d = 3'd0;
         seg2_d = 3'd0;
         fe_d   = FE_IDLE;
      end else if (strobe_c) begin
         case (mode_dec_c)
            MODE_F8: begin
               if (cpu_addr_i >= 13'h1FF8 && cpu_addr_i <= 13'h1FF9)
                  bank_d = 3'(cpu_addr_i - 13'h1FF8);
            end
            MODE_F6: begin
               if (cpu_addr_i >= 13'h1FF6 && cpu_addr_i <= 13'h1FF9)
                  bank_d = 3'(cpu_addr_i - 13'h1FF6);
            end
            MODE_F4: begin
               if (cpu_addr_i >= 13'h1FF4 && cpu_addr_i <= 13'h1FFB)
                  bank_d = 3'(cpu_addr_i - 13'h1FF4);
            end
            MODE_FE: begin
               if (fe_q == FE_IDLE) begin
                  if (cpu_addr_i == FE_HOT)
                     fe_d = FE_ARMED;
               end else if (cpu_addr_i != FE_HOT) begin
                  bank_d = cpu_data_i[5] ? 3'd0 : 3'd1;
                  fe_d   = FE_IDLE;
               end
            end
            MODE_E0: begin
               case (cpu_addr_i[12:3])
                  10'h3FC: seg0_d = cpu_addr_i[2:0];
                  10'h3FD: seg1_d = cpu_addr_i[2:0];
                  10'h3FE: seg2_d = cpu_addr_i[2:0];
                  default: ;
               endcase
            end
            MODE_3F: begin
               if (!cpu_rnw_i && cpu_addr_i[12:6] == 7'd0)
                  bank_d = cpu_data_i[2:0];
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         mode_q <= mode_i;
         bank_q <= last_bank(mode_i);
         seg0_q <= 3'd0;
         seg1_q <= 3'd0;
         seg2_q <= 3'd0;
         fe_q   <= FE_IDLE;
      end else begin
         mode_q <= mode_d;
         bank_q <= bank_d;
         seg0_q <= seg0_d;
         seg1_q <= seg1_d;
         seg2_q <= seg2_d;
         fe_q   <= fe_d;
      end
   end

   // ROM address is built at 16 bits, then truncated to the BRAM width.
   always_comb begin
      rom_addr_full_c = {4'd0, cpu_addr_i[11:0]};
      case (mode_dec_c)
         MODE_F8, MODE_F6, MODE_F4, MODE_FE:
            rom_addr_full_c = {1'b0, bank_q, cpu_addr_i[11:0]};
         MODE_E0: begin
            case (cpu_addr_i[11:10])
               2'd0:    rom_addr_full_c = {3'd0, seg0_q, cpu_addr_i[9:0]};
               2'd1:    rom_addr_full_c = {3'd0, seg1_q, cpu_addr_i[9:0]};
               2'd2:    rom_addr_full_c = {3'd0, seg2_q, cpu_addr_i[9:0]};
               default: rom_addr_full_c = {3'd0, 3'd7, cpu_addr_i[9:0]};
            endcase
         end
         MODE_3F: begin
            if (cpu_addr_i[11])
               rom_addr_full_c = {5'b11111, cpu_addr_i[10:0]};
            else
               rom_addr_full_c = {2'd0, bank_q, cpu_addr_i[10:0]};
         end
         default: ;
      endcase
   end

   assign rom_addr_o      = rom_addr_full_c[ROM_ADDR_BITS-1:0];
   assign cart_ram_addr_o = cpu_addr_i[SC_RAM_BITS-1:0];
   assign cart_ram_we_o   = sc_wr_port_c & bus_stb_i & ~cpu_rnw_i;
   assign cart_ram_rd_o   = sc_rd_port_c;
   assign bank_o          = (mode_dec_c == MODE_E0) ? seg0_q : bank_q;

`ifdef MAPPER_DIAG_EN
   logic [7:0] switch_cnt_q, switch_cnt_d;

   // Count strobes that move the bank or any E0 segment.
   always_comb begin
      switch_cnt_d = switch_cnt_q;
      if (!mode_chg_c && strobe_c &&
          ({bank_d, seg0_d, seg1_d, seg2_d} != {bank_q, seg0_q, seg1_q, seg2_q}))
         switch_cnt_d = switch_cnt_q + 8'd1;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i)
         switch_cnt_q <= 8'd0;
      else
         switch_cnt_q <= switch_cnt_d;
   end

   // Packed into 16 bits: seg2 and bank contribute their low two bits.
   assign diag_o = {switch_cnt_q, 1'(fe_q), mode_q, seg2_q[1:0], bank_q[1:0]};
`endif

endmodule

// File: tb/tb_cart_mapper.sv
// Self-checking bench for cart_mapper: behavioural bank model checked every cycle plus literal checkpoints.
module tb_cart_mapper;

   localparam int ROM_BITS = 15;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  mode;
   logic        sc_en;
   logic        bus_stb;
   logic [12:0] cpu_addr;
   logic        cpu_rnw;
   logic [7:0]  cpu_data;
   logic [14:0] rom_addr_o;
   logic [6:0]  cart_ram_addr_o;
   logic        cart_ram_we_o;
   logic        cart_ram_rd_o;
   logic [2:0]  bank_o;

   int tests = 0;
   int fails = 0;

   cart_mapper dut (
      .clk_i           (clk),
      .rst_n_i         (rst_n),
      .mode_i          (mode),
      .sc_en_i         (sc_en),
      .bus_stb_i       (bus_stb),
      .cpu_addr_i      (cpu_addr),
      .cpu_rnw_i       (cpu_rnw),
      .cpu_data_i      (cpu_data),
      .rom_addr_o      (rom_addr_o),
      .cart_ram_addr_o (cart_ram_addr_o),
      .cart_ram_we_o   (cart_ram_we_o),
      .cart_ram_rd_o   (cart_ram_rd_o),
      .bank_o          (bank_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, got, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int m_mode = -1;
   int m_bank = 0;
   int m_seg [3];
   bit m_armed = 0;
   bit m_valid = 0;

   function automatic int kind_of(input int m);
      return (m < 0 || m >= 7) ? 0 : m;
   endfunction

   function automatic int start_bank(input int m);
      case (kind_of(m))
         1: return 1;
         2: return 3;
         3: return 7;
         default: return 0;
      endcase
   endfunction

   function automatic int exp_rom(input int a);
      int r;
      int sl;
      int s;
      case (kind_of(m_mode))
         1, 2, 3, 4: r = m_bank * 4096 + a % 4096;
         5: begin
            sl = (a / 1024) % 4;
            s  = (sl == 3) ? 7 : m_seg[sl];
            r  = s * 1024 + a % 1024;
         end
         6: r = ((a / 2048) % 2 == 1) ? ((1 << ROM_BITS) - 2048 + a % 2048)
                                      : m_bank * 2048 + a % 2048;
         default: r = a % 4096;
      endcase
      return r % (1 << ROM_BITS);
   endfunction

   always @(posedge clk) begin : model
      int a;
      int lo;
      int n;
      a = int'(cpu_addr);
      if (!rst_n || int'(mode) != m_mode) begin
         m_mode  = int'(mode);
         m_bank  = start_bank(m_mode);
         m_seg   = '{0, 0, 0};
         m_armed = 0;
         m_valid = 1;
      end else if (bus_stb && !(sc_en && a >= 'h1000 && a < 'h1100)) begin
         case (kind_of(m_mode))
            1, 2, 3: begin
               n  = 1 << kind_of(m_mode);
               lo = 'h1FF8 - (kind_of(m_mode) - 1) * 2;
               if (a >= lo && a < lo + n) m_bank = a - lo;
            end
            4: begin
               if (!m_armed) begin
                  if (a == 'h01FE) m_armed = 1;
               end else if (a != 'h01FE) begin
                  m_bank  = cpu_data[5] ? 0 : 1;
                  m_armed = 0;
               end
            end
            5: if (a >= 'h1FE0 && a <= 'h1FF7) m_seg[(a - 'h1FE0) / 8] = a % 8;
            6: if (!cpu_rnw && a < 64) m_bank = int'(cpu_data) % 8;
            default: ;
         endcase
      end
   end

   // Every-cycle compare against the model.
   always @(negedge clk) begin : compare
      int a;
      a = int'(cpu_addr);
      if (m_valid && rst_n) begin
         chk("rom_addr", 32'(rom_addr_o), 32'(exp_rom(a)));
         chk("bank", 32'(bank_o), 32'((kind_of(m_mode) == 5) ? m_seg[0] : m_bank));
         chk("ram_addr", 32'(cart_ram_addr_o), 32'(a % 128));
         chk("ram_we", 32'(cart_ram_we_o),
             32'(bus_stb && sc_en && !cpu_rnw && a >= 'h1000 && a < 'h1080));
         chk("ram_rd", 32'(cart_ram_rd_o), 32'(sc_en && a >= 'h1080 && a < 'h1100));
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic settle();
      @(negedge clk);
      #1;
   endtask

   task automatic strobe(input logic [12:0] a, input logic rnw, input logic [7:0] d);
      bus_stb  = 1'b1;
      cpu_addr = a;
      cpu_rnw  = rnw;
      cpu_data = d;
      tick();
      bus_stb  = 1'b0;
      cpu_rnw  = 1'b1;
   endtask

   task automatic peek(input logic [12:0] a);
      cpu_addr = a;
      settle();
   endtask

   task automatic set_mode(input logic [2:0] m);
      mode = m;
      tick();
   endtask

   initial begin
      rst_n    = 1'b0;
      mode     = 3'd2;
      sc_en    = 1'b0;
      bus_stb  = 1'b0;
      cpu_addr = 13'h1000;
      cpu_rnw  = 1'b1;
      cpu_data = 8'h00;
      tick();
      tick();
      rst_n = 1'b1;

      // F6 reset state, then hotspot 1FF7
      peek(13'h1000);
      chk("f6_reset_bank", 32'(bank_o), 32'd3);
      chk("f6_reset_rom", 32'(rom_addr_o), 32'h3000);
      strobe(13'h1FF7, 1'b1, 8'h00);
      peek(13'h1234);
      chk("f6_1ff7_bank", 32'(bank_o), 32'd1);
      chk("f6_1ff7_rom", 32'(rom_addr_o), 32'h1234);

      // F4
      set_mode(3'd3);
      peek(13'h1000);
      chk("f4_reset_bank", 32'(bank_o), 32'd7);
      strobe(13'h1FF4, 1'b1, 8'h00);
      strobe(13'h1FFB, 1'b1, 8'h00);
      peek(13'h1000);
      chk("f4_1ffb_bank", 32'(bank_o), 32'd7);
      strobe(13'h1FF4, 1'b0, 8'h00);
      peek(13'h1000);
      chk("f4_1ff4_bank", 32'(bank_o), 32'd0);
      strobe(13'h0FF5, 1'b1, 8'h00);
      peek(13'h1000);
      chk("f4_a12_low_bank", 32'(bank_o), 32'd0);

      // FE
      set_mode(3'd4);
      strobe(13'h01FE, 1'b1, 8'hFF);
      strobe(13'h01FE, 1'b1, 8'hFF);
      strobe(13'h1000, 1'b1, 8'h00);
      peek(13'h1000);
      chk("fe_data00_bank", 32'(bank_o), 32'd1);
      strobe(13'h01FE, 1'b1, 8'h00);
      strobe(13'h1000, 1'b1, 8'h20);
      peek(13'h1000);
      chk("fe_data20_bank", 32'(bank_o), 32'd0);
      strobe(13'h1000, 1'b1, 8'h00);
      peek(13'h1000);
      chk("fe_unarmed_bank", 32'(bank_o), 32'd0);

      // E0
      set_mode(3'd5);
      strobe(13'h1FE5, 1'b1, 8'h00);
      strobe(13'h1FEA, 1'b1, 8'h00);
      strobe(13'h1FF3, 1'b1, 8'h00);
      peek(13'h1000);
      chk("e0_slice0", 32'(rom_addr_o), 32'h1400);
      chk("e0_bank_seg0", 32'(bank_o), 32'd5);
      peek(13'h1400);
      chk("e0_slice1", 32'(rom_addr_o), 32'h0800);
      peek(13'h1800);
      chk("e0_slice2", 32'(rom_addr_o), 32'h0C00);
      peek(13'h1C00);
      chk("e0_slice3", 32'(rom_addr_o), 32'h1C00);

      // 3F
      set_mode(3'd6);
      strobe(13'h003F, 1'b0, 8'h02);
      peek(13'h1000);
      chk("3f_low", 32'(rom_addr_o), 32'h1000);
      peek(13'h1800);
      chk("3f_high", 32'(rom_addr_o), 32'h7800);
      strobe(13'h003F, 1'b1, 8'h05);
      peek(13'h1000);
      chk("3f_read_nochange", 32'(rom_addr_o), 32'h1000);

      // Mode 7 behaves as none
      set_mode(3'd7);
      strobe(13'h1FF8, 1'b1, 8'h00);
      peek(13'h1ABC);
      chk("mode7_rom", 32'(rom_addr_o), 32'h0ABC);

      // Superchip with F8
      set_mode(3'd1);
      sc_en    = 1'b1;
      bus_stb  = 1'b1;
      cpu_rnw  = 1'b0;
      cpu_data = 8'h5A;
      cpu_addr = 13'h1005;
      settle();
      chk("sc_we", 32'(cart_ram_we_o), 32'd1);
      chk("sc_addr", 32'(cart_ram_addr_o), 32'h05);
      tick();
      bus_stb = 1'b0;
      cpu_rnw = 1'b1;
      peek(13'h1085);
      chk("sc_rd", 32'(cart_ram_rd_o), 32'd1);
      chk("sc_rd_no_we", 32'(cart_ram_we_o), 32'd0);
      strobe(13'h1FF8, 1'b1, 8'h00);
      peek(13'h1000);
      chk("f8_1ff8_bank", 32'(bank_o), 32'd0);
      // Strobe in the mode-change cycle is ignored
      mode = 3'd2;
      strobe(13'h1FF6, 1'b1, 8'h00);
      peek(13'h1000);
      chk("f8_to_f6_bank", 32'(bank_o), 32'd3);
      sc_en    = 1'b0;
      bus_stb  = 1'b1;
      cpu_rnw  = 1'b0;
      cpu_addr = 13'h1005;
      settle();
      chk("sc_off_we", 32'(cart_ram_we_o), 32'd0);
      tick();
      bus_stb = 1'b0;
      cpu_rnw = 1'b1;

      // Reset wins over a simultaneous strobe
      rst_n = 1'b0;
      strobe(13'h1FF6, 1'b1, 8'h00);
      rst_n = 1'b1;
      peek(13'h1000);
      chk("reset_wins_bank", 32'(bank_o), 32'd3);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
